// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator sequencer.
// Holds the FSM state encoding, operator and display-select enums, and the
// operand/result widths used by the number registers and the ALU.
package calc_pkg;

    localparam int NUM_W = 14;
    localparam int RES_W = 28;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        SHOW,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        DISP_A      = 2'd0,
        DISP_B      = 2'd1,
        DISP_RESULT = 2'd2,
        DISP_ERROR  = 2'd3
    } disp_t;

    // Division by zero is caught before the ALU is ever started.
    function automatic logic is_div_by_zero(op_t op, logic [NUM_W-1:0] divisor);
        return (op == DIV) && (divisor == '0);
    endfunction

    // What the display shows in each state.
    function automatic disp_t state_disp(state_t st);
        case (st)
            ENTER_A: return DISP_A;
            SHOW:    return DISP_RESULT;
            ERROR:   return DISP_ERROR;
            default: return DISP_B;
        endcase
    endfunction

endpackage

// File: rtl/calc_watchdog.sv
// calc_watchdog: counts cycles spent waiting on the ALU and flags expiry.
// Built only with CALC_TIMEOUT_EN defined; otherwise this file is empty.
// The counter is held at zero while clear is high and advances once per
// cycle otherwise, saturating at TIMEOUT_CYCLES-1 where expired is raised.
`ifdef CALC_TIMEOUT_EN
module calc_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_ext,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next count: restart on clear, otherwise step until expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/calc_sequencer.sv
// calc_sequencer: top-level FSM for a calculator session.
// Steers slider entry between operand A and B, latches the operator, runs the
// ALU start/done handshake, holds the result and chooses the display source.
// Optional feature macro: CALC_TIMEOUT_EN (abort to ERROR if the ALU stays
// silent for TIMEOUT_CYCLES cycles in WAIT).
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_ext,
    input  logic                    btn_next,
    input  logic                    btn_eq,
    input  logic                    btn_clr,
    input  logic [1:0]              op_sel,
    input  logic [NUM_W-1:0]        number_1,
    input  logic [NUM_W-1:0]        number_2,
    output logic                    write_number_select,
    output logic                    clr_operands,
    output logic                    alu_start,
    output logic [1:0]              alu_op,
    input  logic                    alu_done,
    input  logic                    alu_err,
    input  logic signed [RES_W-1:0] alu_result,
    output logic signed [RES_W-1:0] result,
    output logic                    result_valid,
    output logic [1:0]              disp_sel,
    output logic                    error
);

    state_t                  state_q, state_d;
    op_t                     alu_op_q, alu_op_d;
    logic signed [RES_W-1:0] result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    clr_operands_q, clr_operands_d;
    logic                    alu_start_q, alu_start_d;
    logic                    wsel_q, wsel_d;
    disp_t                   disp_sel_q, disp_sel_d;
    logic                    error_q, error_d;
    logic                    timeout_hit;

    // Operand A goes straight to the ALU; the sequencer never looks at it.
    logic unused_number_1;
    assign unused_number_1 = ^number_1;

`ifdef CALC_TIMEOUT_EN
    calc_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_ext (rst_ext),
        .clear   (state_q != WAIT),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Next-state, result capture and registered Moore outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d        = state_q;
        alu_op_d       = alu_op_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        clr_operands_d = 1'b0;

        if (btn_clr) begin
            state_d        = ENTER_A;
            clr_operands_d = 1'b1;
            result_d       = '0;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (btn_next) state_d = ENTER_B;
                end
                ENTER_B: begin
                    if (btn_eq) begin
                        alu_op_d = op_t'(op_sel);
                        state_d  = is_div_by_zero(op_t'(op_sel), number_2) ? ERROR : START;
                    end else if (btn_next) begin
                        state_d = ENTER_A;
                    end
                end
                START: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            state_d = ERROR;
                        end else begin
                            result_d       = alu_result;
                            result_valid_d = 1'b1;
                            state_d        = SHOW;
                        end
                    end else if (timeout_hit) begin
                        state_d = ERROR;
                    end
                end
                SHOW: begin
                    if (btn_next) begin
                        state_d        = ENTER_A;
                        clr_operands_d = 1'b1;
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = ENTER_A;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        alu_start_d = (state_d == START);
        wsel_d      = (state_d != ENTER_A);
        disp_sel_d  = state_disp(state_d);
        error_d     = (state_d == ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (rst_ext) begin
            state_q        <= ENTER_A;
            alu_op_q       <= ADD;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            clr_operands_q <= 1'b0;
            alu_start_q    <= 1'b0;
            wsel_q         <= 1'b0;
            disp_sel_q     <= DISP_A;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            alu_op_q       <= alu_op_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            clr_operands_q <= clr_operands_d;
            alu_start_q    <= alu_start_d;
            wsel_q         <= wsel_d;
            disp_sel_q     <= disp_sel_d;
            error_q        <= error_d;
        end
    end

    assign write_number_select = wsel_q;
    assign clr_operands        = clr_operands_q;
    assign alu_start           = alu_start_q;
    assign alu_op              = alu_op_q;
    assign result              = result_q;
    assign result_valid        = result_valid_q;
    assign disp_sel            = disp_sel_q;
    assign error               = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scenario tasks plus a randomized session loop checked
// against a plain-arithmetic reference for the ALU and expected display/flags.
module tb_calc_sequencer;

    localparam int TB_TIMEOUT = 8;

    // Observed tuple: {disp_sel[1:0], alu_start, error, clr_operands}
    localparam logic [4:0] O_A     = 5'b00_0_0_0;
    localparam logic [4:0] O_B     = 5'b01_0_0_0;
    localparam logic [4:0] O_START = 5'b01_1_0_0;
    localparam logic [4:0] O_WAIT  = 5'b01_0_0_0;
    localparam logic [4:0] O_SHOW  = 5'b10_0_0_0;
    localparam logic [4:0] O_ERR   = 5'b11_0_1_0;
    localparam logic [4:0] O_CLR   = 5'b00_0_0_1;

    logic               clk = 1'b0;
    logic               rst_ext, btn_next, btn_eq, btn_clr;
    logic [1:0]         op_sel;
    logic [13:0]        number_1, number_2;
    logic               write_number_select, clr_operands, alu_start;
    logic [1:0]         alu_op;
    logic               alu_done, alu_err;
    logic signed [27:0] alu_result;
    logic signed [27:0] result;
    logic               result_valid;
    logic [1:0]         disp_sel;
    logic               error;

    int checks   = 0;
    int failures = 0;

    logic signed [27:0] exp_result = '0;
    logic               exp_valid  = 1'b0;

    calc_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk                 (clk),
        .rst_ext             (rst_ext),
        .btn_next            (btn_next),
        .btn_eq              (btn_eq),
        .btn_clr             (btn_clr),
        .op_sel              (op_sel),
        .number_1            (number_1),
        .number_2            (number_2),
        .write_number_select (write_number_select),
        .clr_operands        (clr_operands),
        .alu_start           (alu_start),
        .alu_op              (alu_op),
        .alu_done            (alu_done),
        .alu_err             (alu_err),
        .alu_result          (alu_result),
        .result              (result),
        .result_valid        (result_valid),
        .disp_sel            (disp_sel),
        .error               (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "time limit");
    end

    function automatic logic [4:0] outs();
        return {disp_sel, alu_start, error, clr_operands};
    endfunction

    // Reference ALU arithmetic on the decimal operands.
    function automatic logic signed [27:0] golden(int op, int a, int b);
        case (op)
            0:       return 28'(a + b);
            1:       return 28'(a - b);
            2:       return 28'(a * b);
            default: return 28'(a / b);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic nx, input logic eq, input logic cl);
        btn_next = nx; btn_eq = eq; btn_clr = cl;
        tick();
        btn_next = 1'b0; btn_eq = 1'b0; btn_clr = 1'b0;
    endtask

    task automatic alu_respond(input logic signed [27:0] res, input logic err, input logic cl);
        alu_done = 1'b1; alu_err = err; alu_result = res; btn_clr = cl;
        tick();
        alu_done = 1'b0; alu_err = 1'b0; btn_clr = 1'b0;
        alu_result = 28'($urandom);
    endtask

    // From ENTER_A: select B, set up the operation and press equals.
    task automatic launch(input int op, input int a, input int b, input logic together);
        pulse(1'b1, 1'b0, 1'b0);
        op_sel = 2'(op); number_1 = 14'(a); number_2 = 14'(b);
        pulse(together, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_ext = 1'b1;
        btn_next = 0; btn_eq = 0; btn_clr = 0; alu_done = 0; alu_err = 0;
        alu_result = '0; op_sel = 2'd2; number_1 = 14'd7; number_2 = 14'd3;
        tick(); tick();
        rst_ext = 1'b0;
        checks++; if (outs() !== O_A) begin failures++; $display("FAIL reset_outs: got %b want %b", outs(), O_A); end
        checks++; if ({write_number_select, alu_op, result_valid} !== 4'b0) begin failures++;
            $display("FAIL reset_flags: wsel=%b op=%0d valid=%b want all 0", write_number_select, alu_op, result_valid); end
        checks++; if (result !== 28'sd0) begin failures++; $display("FAIL reset_result: got %0d want 0", result); end
    endtask

    task automatic test_basic();
        int starts;
        checks++; if (write_number_select !== 1'b0) begin failures++; $display("FAIL basic_wsel_a: got %b want 0", write_number_select); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (write_number_select !== 1'b1 || outs() !== O_B) begin failures++;
            $display("FAIL basic_enter_b: wsel=%b outs=%b want 1 %b", write_number_select, outs(), O_B); end
        op_sel = 2'd0; number_1 = 14'd40; number_2 = 14'd2;
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if (outs() !== O_START || alu_op !== 2'd0) begin failures++;
            $display("FAIL basic_start: outs=%b op=%0d want %b 0", outs(), alu_op, O_START); end
        starts = 1;
        repeat (4) begin
            tick();
            if (alu_start) starts++;
        end
        checks++; if (starts !== 1) begin failures++; $display("FAIL basic_start_width: got %0d cycles want 1", starts); end
        checks++; if (outs() !== O_WAIT || result_valid !== 1'b0) begin failures++;
            $display("FAIL basic_wait: outs=%b valid=%b want %b 0", outs(), result_valid, O_WAIT); end
        alu_respond(28'sd42, 1'b0, 1'b0);
        exp_result = 28'sd42; exp_valid = 1'b1;
        checks++; if (result !== exp_result || result_valid !== 1'b1 || outs() !== O_SHOW) begin failures++;
            $display("FAIL basic_show: result=%0d valid=%b outs=%b want 42 1 %b", result, result_valid, outs(), O_SHOW); end
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if (outs() !== O_SHOW) begin failures++; $display("FAIL basic_eq_in_show: outs=%b want %b", outs(), O_SHOW); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (outs() !== O_CLR || result !== exp_result || result_valid !== 1'b1) begin failures++;
            $display("FAIL basic_next_from_show: outs=%b result=%0d valid=%b want %b 42 1", outs(), result, result_valid, O_CLR); end
        tick();
        checks++; if (outs() !== O_A) begin failures++; $display("FAIL basic_clr_pulse_end: outs=%b want %b", outs(), O_A); end
    endtask

    task automatic test_div_zero();
        int starts = 0;
        launch(3, 1234, 0, 1'b0);
        checks++; if (outs() !== O_ERR || alu_op !== 2'd3) begin failures++;
            $display("FAIL div0_error: outs=%b op=%0d want %b 3", outs(), alu_op, O_ERR); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) alu_respond(28'sd5, 1'b0, 1'b0);
            else pulse(1'b1, i[0], 1'b0);
            if (alu_start) starts++;
        end
        checks++; if (outs() !== O_ERR || starts !== 0) begin failures++;
            $display("FAIL div0_sticky: outs=%b starts=%0d want %b 0", outs(), starts, O_ERR); end
        pulse(1'b0, 1'b0, 1'b1);
        exp_result = '0; exp_valid = 1'b0;
        checks++; if (outs() !== O_CLR || result_valid !== 1'b0 || result !== 28'sd0) begin failures++;
            $display("FAIL div0_clr: outs=%b valid=%b result=%0d want %b 0 0", outs(), result_valid, result, O_CLR); end
        tick();
        checks++; if (outs() !== O_A) begin failures++; $display("FAIL div0_clr_single: outs=%b want %b", outs(), O_A); end
    endtask

    task automatic test_back_to_back_buttons();
        launch(2, 300, 17, 1'b1);
        checks++; if (outs() !== O_START || alu_op !== 2'd2) begin failures++;
            $display("FAIL next_eq_together: outs=%b op=%0d want %b 2", outs(), alu_op, O_START); end
        tick();
        alu_respond(golden(2, 300, 17), 1'b0, 1'b0);
        exp_result = golden(2, 300, 17); exp_valid = 1'b1;
        checks++; if (result !== exp_result || outs() !== O_SHOW) begin failures++;
            $display("FAIL together_result: result=%0d outs=%b want %0d %b", result, outs(), exp_result, O_SHOW); end
        pulse(1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_clr_in_wait();
        launch(1, 10, 20, 1'b0);
        tick();
        pulse(1'b0, 1'b0, 1'b1);
        exp_result = '0; exp_valid = 1'b0;
        checks++; if (outs() !== O_CLR || result_valid !== 1'b0) begin failures++;
            $display("FAIL clr_wait: outs=%b valid=%b want %b 0", outs(), result_valid, O_CLR); end
        alu_respond(28'sd999, 1'b0, 1'b0);
        checks++; if (outs() !== O_A || result_valid !== 1'b0 || result !== 28'sd0) begin failures++;
            $display("FAIL late_done: outs=%b valid=%b result=%0d want %b 0 0", outs(), result_valid, result, O_A); end
        launch(0, 5, 6, 1'b0);
        tick();
        alu_respond(28'sd11, 1'b0, 1'b1);
        checks++; if (outs() !== O_CLR || result_valid !== 1'b0 || result !== 28'sd0) begin failures++;
            $display("FAIL done_with_clr: outs=%b valid=%b result=%0d want %b 0 0", outs(), result_valid, result, O_CLR); end
        tick();
    endtask

    task automatic test_alu_err();
        launch(1, 5, 900, 1'b0);
        tick();
        alu_respond(golden(1, 5, 900), 1'b0, 1'b0);
        exp_result = golden(1, 5, 900); exp_valid = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        launch(2, 77, 88, 1'b0);
        tick();
        alu_respond(28'sd12345, 1'b1, 1'b0);
        checks++; if (outs() !== O_ERR || result !== exp_result || result_valid !== exp_valid) begin failures++;
            $display("FAIL alu_err: outs=%b result=%0d valid=%b want %b %0d %b", outs(), result, result_valid, O_ERR, exp_result, exp_valid); end
        pulse(1'b0, 1'b0, 1'b1);
        exp_result = '0; exp_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        launch(0, 1, 2, 1'b0);
        tick();
        rst_ext = 1'b1;
        tick();
        rst_ext = 1'b0;
        alu_respond(28'sd3, 1'b0, 1'b0);
        checks++; if (outs() !== O_A || result_valid !== 1'b0 || alu_op !== 2'd0) begin failures++;
            $display("FAIL reset_in_wait: outs=%b valid=%b op=%0d want %b 0 0", outs(), result_valid, alu_op, O_A); end
    endtask

    task automatic test_timeout();
        int n = 0;
        launch(3, 50, 5, 1'b0);
        tick();
`ifdef CALC_TIMEOUT_EN
        while (!error && n < 200) begin
            tick();
            n++;
        end
        checks++; if (n !== TB_TIMEOUT || outs() !== O_ERR) begin failures++;
            $display("FAIL timeout: error after %0d cycles outs=%b want %0d %b", n, outs(), TB_TIMEOUT, O_ERR); end
`else
        repeat (100) begin
            tick();
            n++;
        end
        checks++; if (outs() !== O_WAIT || n !== 100) begin failures++;
            $display("FAIL no_timeout: outs=%b after %0d cycles want %b", outs(), n, O_WAIT); end
`endif
        pulse(1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_random_sessions();
        for (int it = 0; it < 40; it++) begin
            int op, a, b, lat;
            logic err;
            logic signed [27:0] g;
            op = int'($urandom_range(3));
            a  = int'($urandom_range(9999));
            b  = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(9999));
            if ($urandom_range(3) == 0) begin
                alu_respond(28'($urandom), 1'b0, 1'b0);
                checks++; if (outs() !== O_A || result !== exp_result || result_valid !== exp_valid) begin failures++;
                    $display("FAIL rnd_stray_done it=%0d: outs=%b result=%0d want %b %0d", it, outs(), result, O_A, exp_result); end
            end
            launch(op, a, b, 1'($urandom_range(1)));
            if (op == 3 && b == 0) begin
                checks++; if (outs() !== O_ERR) begin failures++;
                    $display("FAIL rnd_div0 it=%0d: outs=%b want %b", it, outs(), O_ERR); end
                pulse(1'b0, 1'b0, 1'b1);
                exp_result = '0; exp_valid = 1'b0;
                tick();
                continue;
            end
            checks++; if (outs() !== O_START || alu_op !== 2'(op)) begin failures++;
                $display("FAIL rnd_start it=%0d: outs=%b op=%0d want %b %0d", it, outs(), alu_op, O_START, op); end
            tick();
            lat = int'($urandom_range(4));
            for (int k = 0; k < lat; k++) begin
                pulse(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
                checks++; if (outs() !== O_WAIT) begin failures++;
                    $display("FAIL rnd_wait it=%0d: outs=%b want %b", it, outs(), O_WAIT); end
            end
            g   = golden(op, a, b);
            err = ($urandom_range(7) == 0);
            alu_respond(g, err, 1'b0);
            if (err) begin
                checks++; if (outs() !== O_ERR || result !== exp_result || result_valid !== exp_valid) begin failures++;
                    $display("FAIL rnd_err it=%0d: outs=%b result=%0d want %b %0d", it, outs(), result, O_ERR, exp_result); end
                pulse(1'b0, 1'b0, 1'b1);
                exp_result = '0; exp_valid = 1'b0;
            end else begin
                exp_result = g; exp_valid = 1'b1;
                checks++; if (outs() !== O_SHOW || result !== exp_result || result_valid !== 1'b1) begin failures++;
                    $display("FAIL rnd_result it=%0d op=%0d a=%0d b=%0d: result=%0d outs=%b want %0d %b",
                             it, op, a, b, result, outs(), exp_result, O_SHOW); end
                pulse(1'b1, 1'b0, 1'b0);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back_buttons();
        test_clr_in_wait();
        test_alu_err();
        test_reset_mid_wait();
        test_timeout();
        test_random_sessions();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Top-level FSM that sequences a calculator session on the board.
- Steers operand entry (operand A, then operand B) into the slider-driven number registers.
- Latches the operator, hands off to the arithmetic unit with a start/done handshake, holds the result and selects what the display shows.
- Sits between the debounced buttons, the slider-entry block and the ALU.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before error (used only with CALC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst_ext  in  1  synchronous active-high reset
- btn_next  in  1  one-cycle debounced pulse: switch operand / start new entry
- btn_eq  in  1  one-cycle pulse: compute
- btn_clr  in  1  one-cycle pulse: abort and clear
- op_sel  in  2  operator switches: 0 ADD, 1 SUB, 2 MUL, 3 DIV
- number_1  in  14  operand A, 0..9999
- number_2  in  14  operand B, 0..9999
- write_number_select  out  1  0 = sliders edit A, 1 = sliders edit B
- clr_operands  out  1  one-cycle pulse that clears the operand registers
- alu_start  out  1  one-cycle start pulse
- alu_op  out  2  latched operator
- alu_done  in  1  one-cycle completion pulse
- alu_err  in  1  valid with alu_done; arithmetic error
- alu_result  in  28  signed result, valid with alu_done
- result  out  28  latched signed result
- result_valid  out  1  result holds a completed computation
- disp_sel  out  2  0 A, 1 B, 2 result, 3 error pattern
- error  out  1  in ERROR state

Behaviour:
- Reset (rst_ext=1 at clk edge): state ENTER_A; result=0, result_valid=0, alu_start=0, alu_op=0, clr_operands=0, write_number_select=0, disp_sel=0, error=0.
- Reset mid-WAIT abandons the operation. alu_done is ignored in every state except WAIT.
- States and outputs (Moore, registered):
  - ENTER_A: wsel=0, disp 0.
  - ENTER_B: wsel=1, disp 1.
  - START: alu_start=1, disp 1.
  - WAIT: disp 1.
  - SHOW: disp 2.
  - ERROR: disp 3, error=1.
- btn_clr has highest priority in every state:
  - Next state is ENTER_A.
  - clr_operands pulses high for exactly the following cycle.
  - result=0, result_valid=0.
- Transitions:
  - ENTER_A: btn_next -> ENTER_B.
  - ENTER_B: btn_eq -> latch op_sel into alu_op. If op_sel==DIV and number_2==0, go to ERROR (ALU not started); otherwise go to START. btn_next alone -> ENTER_A. If btn_next and btn_eq arrive together, btn_eq wins.
  - START: one cycle only, then unconditionally to WAIT. alu_start is high only in START.
  - WAIT: alu_done && !alu_err -> result<=alu_result, result_valid<=1, go to SHOW. alu_done && alu_err -> ERROR. alu_done in the same cycle as btn_clr is dropped.
  - SHOW: btn_next -> ENTER_A and pulses clr_operands; result and result_valid are kept until the next compute. btn_eq ignored.
  - ERROR: exits only via btn_clr or reset.
- alu_op is stable from START until the next btn_eq.
- Operands are not copied; the ALU samples number_1/number_2 directly while in START/WAIT. wsel=1 in those states, but button presses other than btn_clr are ignored.
- Buttons are ignored in START/WAIT (except btn_clr).
- Latency: btn_eq edge -> alu_start high on the next cycle. alu_done -> result_valid high on the next cycle.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
  - Defined: a cycle counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without alu_done, the next state is ERROR. alu_done in that same cycle takes priority over the timeout.
  - Undefined: no counter; WAIT holds indefinitely until alu_done or btn_clr.

Decomposition:
- Shared package calc_pkg holds:
  - state enum: ENTER_A, ENTER_B, START, WAIT, SHOW, ERROR
  - op enum: ADD, SUB, MUL, DIV
  - disp_sel enum
  - constants NUM_W=14, RES_W=28
- One natural sub-module: calc_watchdog (timeout counter; start/clear in, expired out), instantiated only under CALC_TIMEOUT_EN.
- FSM and result register stay in calc_sequencer.

Test Plan:
- Reset, btn_next, set op_sel=0, btn_eq; ALU model returns done with result 42 after 5 cycles.
  - Required: wsel 0->1; alu_start high exactly 1 cycle; alu_op=0; result=42, result_valid=1, disp_sel=2.
- number_2=0, op_sel=3, btn_eq in ENTER_B.
  - Required: ERROR next cycle, alu_start never high, disp_sel=3. btn_next ignored; btn_clr -> ENTER_A with clr_operands a single 1-cycle pulse.
- btn_next and btn_eq asserted in the same cycle in ENTER_B.
  - Required: START taken.
- btn_clr in WAIT, then alu_done the cycle after.
  - Required: state ENTER_A, result_valid=0, late done ignored.
- ALU returns alu_err=1 with done.
  - Required: ERROR, result unchanged.
- CALC_TIMEOUT_EN with TIMEOUT_CYCLES=8, ALU never responds.
  - Required: ERROR exactly 8 cycles after entering WAIT.
  - Without the macro: still in WAIT after 100 cycles.
